// File: rtl/brg_sram_1024x46_req_adapter.sv
// Valid/ready request front-end for a 1024x46 single-port SRAM, with a
// credit-gated 3-entry response FIFO that captures read data one cycle after access.
module brg_sram_1024x46_req_adapter #(
  parameter int width_p       = 46,
  parameter int els_p         = 1024,
  parameter int addr_width_lp = $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     req_v_i,
  output logic                     req_ready_o,
  input  logic                     req_w_i,
  input  logic [addr_width_lp-1:0] req_addr_i,
  input  logic [width_p-1:0]       req_data_i,
  output logic                     rsp_v_o,
  output logic [width_p-1:0]       rsp_data_o,
  input  logic                     rsp_yumi_i,
  output logic                     sram_v_o,
  output logic                     sram_w_o,
  output logic [addr_width_lp-1:0] sram_addr_o,
  output logic [width_p-1:0]       sram_data_o,
  input  logic [width_p-1:0]       sram_data_i
);

  // Handshakes: a request transfers on any cycle where req_v_i & req_ready_o;
  // a response transfers when rsp_v_o & rsp_yumi_i. Ready never depends on valid.
  logic               pending_q, pending_d;
  logic [1:0]         count_q, count_d;
  logic [1:0]         wptr_q, wptr_d;
  logic [1:0]         rptr_q, rptr_d;
  logic [width_p-1:0] mem_q [3];

  logic acc, enq, deq;
  logic [2:0] credit_used;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Every in-flight read already owns a FIFO slot, so the FIFO cannot overflow.
  assign credit_used = {1'b0, count_q} + {2'b00, pending_q};
  assign req_ready_o = (credit_used < 3'd3) & ~reset_i;
  assign acc         = req_v_i & req_ready_o;

  assign sram_v_o    = acc;
  assign sram_w_o    = req_w_i;
  assign sram_addr_o = req_addr_i;
  assign sram_data_o = req_data_i;

  assign rsp_v_o    = (count_q != 2'd0);
  assign rsp_data_o = mem_q[rptr_q];

  assign enq = pending_q;
  assign deq = rsp_yumi_i & rsp_v_o;

  always_comb begin
    pending_d = acc & ~req_w_i;
    wptr_d    = enq ? ptr_inc(wptr_q) : wptr_q;
    rptr_d    = deq ? ptr_inc(rptr_q) : rptr_q;
    count_d   = count_q;
    if (enq && !deq) count_d = count_q + 2'd1;
    else if (!enq && deq) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pending_q <= 1'b0;
      count_q   <= 2'd0;
      wptr_q    <= 2'd0;
      rptr_q    <= 2'd0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
    end
  end

  // Data storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q] <= sram_data_i;
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(enq && !deq && count_q == 2'd3))
    else $error("response FIFO overflow");

  a_no_illegal_yumi: assert property (@(posedge clk_i) disable iff (reset_i)
    !(rsp_yumi_i && !rsp_v_o))
    else $error("rsp_yumi_i asserted while rsp_v_o=0");

endmodule

// File: tb/tb_brg_sram_1024x46_req_adapter.sv
// Directed bench for brg_sram_1024x46_req_adapter: behavioural SRAM model,
// per-scenario tasks with inline checks against an expected-data queue.
module tb_brg_sram_1024x46_req_adapter;

  logic        clk_i;
  logic        reset_i;
  logic        req_v_i;
  logic        req_ready_o;
  logic        req_w_i;
  logic [9:0]  req_addr_i;
  logic [45:0] req_data_i;
  logic        rsp_v_o;
  logic [45:0] rsp_data_o;
  logic        rsp_yumi_i;
  logic        sram_v_o;
  logic        sram_w_o;
  logic [9:0]  sram_addr_o;
  logic [45:0] sram_data_o;
  logic [45:0] sram_data_i;

  int checks = 0;
  int errors = 0;
  logic [45:0] exp_q[$];

  localparam logic [45:0] JUNK = 46'h2BAD_0BAD_F00D;
  localparam logic [45:0] TOP_DATA = 46'h155_5555_AAAA;

  brg_sram_1024x46_req_adapter dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .req_v_i    (req_v_i),
    .req_ready_o(req_ready_o),
    .req_w_i    (req_w_i),
    .req_addr_i (req_addr_i),
    .req_data_i (req_data_i),
    .rsp_v_o    (rsp_v_o),
    .rsp_data_o (rsp_data_o),
    .rsp_yumi_i (rsp_yumi_i),
    .sram_v_o   (sram_v_o),
    .sram_w_o   (sram_w_o),
    .sram_addr_o(sram_addr_o),
    .sram_data_o(sram_data_o),
    .sram_data_i(sram_data_i)
  );

  // Clock / reset
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Synchronous-read SRAM; its output carries junk on every non-read cycle.
  logic [45:0] sram_mem [1024];
  always @(posedge clk_i) begin
    if (sram_v_o && sram_w_o) sram_mem[sram_addr_o] <= sram_data_o;
    if (sram_v_o && !sram_w_o) sram_data_i <= sram_mem[sram_addr_o];
    else sram_data_i <= JUNK;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [9:0] a, input logic [45:0] d);
    req_v_i    = v;
    req_w_i    = w;
    req_addr_i = a;
    req_data_i = d;
  endtask

  task automatic sram_wr(input logic [9:0] a, input logic [45:0] d);
    drive(1'b1, 1'b1, a, d);
    #1;
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL wr_ready addr %h: got %b expected 1", a, req_ready_o);
    end
    tick();
    drive(1'b0, 1'b0, 10'h0, 46'h0);
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    drive(1'b1, 1'b0, 10'h005, 46'h0);
    #1;
    checks++;
    if (req_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", req_ready_o); end
    checks++;
    if (rsp_v_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_v: got %b expected 0", rsp_v_o); end
    checks++;
    if (sram_v_o !== 1'b0) begin errors++; $display("FAIL reset_sram_v: got %b expected 0", sram_v_o); end
    tick();
    tick();
    drive(1'b0, 1'b0, 10'h0, 46'h0);
    reset_i = 1'b0;
    tick();
    checks++;
    if (req_ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", req_ready_o); end
    checks++;
    if (rsp_v_o !== 1'b0) begin errors++; $display("FAIL post_reset_rsp_v: got %b expected 0", rsp_v_o); end
  endtask

  task automatic test_single_read();
    sram_wr(10'h3FF, TOP_DATA);
    drive(1'b1, 1'b0, 10'h3FF, 46'h0);
    #1;
    checks++;
    if (req_ready_o !== 1'b1 || sram_v_o !== 1'b1 || sram_w_o !== 1'b0 || sram_addr_o !== 10'h3FF) begin
      errors++;
      $display("FAIL single_sram_drive: got v=%b w=%b a=%h rdy=%b expected v=1 w=0 a=3ff rdy=1",
               sram_v_o, sram_w_o, sram_addr_o, req_ready_o);
    end
    tick();
    drive(1'b0, 1'b0, 10'h0, 46'h0);
    #1;
    checks++;
    if (rsp_v_o !== 1'b0) begin errors++; $display("FAIL single_lat1: got rsp_v %b expected 0", rsp_v_o); end
    tick();
    checks++;
    if (rsp_v_o !== 1'b1) begin errors++; $display("FAIL single_lat2: got rsp_v %b expected 1", rsp_v_o); end
    checks++;
    if (rsp_data_o !== TOP_DATA) begin
      errors++;
      $display("FAIL single_data: got %h expected %h", rsp_data_o, TOP_DATA);
    end
    rsp_yumi_i = rsp_v_o;
    tick();
    rsp_yumi_i = 1'b0;
    checks++;
    if (rsp_v_o !== 1'b0) begin errors++; $display("FAIL single_after: got rsp_v %b expected 0", rsp_v_o); end
  endtask

  task automatic test_streaming();
    int got = 0;
    logic [45:0] e;
    for (int i = 0; i < 16; i++) sram_wr(10'(i), 46'(i));
    exp_q.delete();
    for (int c = 0; c < 20; c++) begin
      if (c < 16) drive(1'b1, 1'b0, 10'(c), 46'h0);
      else drive(1'b0, 1'b0, 10'h0, 46'h0);
      #1;
      if (c < 16) begin
        checks++;
        if (req_ready_o !== 1'b1) begin errors++; $display("FAIL stream_ready c=%0d: got %b expected 1", c, req_ready_o); end
        if (req_ready_o === 1'b1) exp_q.push_back(46'(c));
      end
      if (c >= 2 && c < 18) begin
        checks++;
        if (rsp_v_o !== 1'b1) begin errors++; $display("FAIL stream_rsp_v c=%0d: got %b expected 1", c, rsp_v_o); end
      end
      rsp_yumi_i = rsp_v_o;
      if (rsp_v_o === 1'b1) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : JUNK;
        checks++;
        if (rsp_data_o !== e) begin errors++; $display("FAIL stream_data c=%0d: got %h expected %h", c, rsp_data_o, e); end
        got++;
      end
      tick();
    end
    rsp_yumi_i = 1'b0;
    checks++;
    if (got !== 16) begin errors++; $display("FAIL stream_count: got %0d expected 16", got); end
  endtask

  task automatic test_backpressure();
    int accepts = 0;
    logic [45:0] e;
    exp_q.delete();
    rsp_yumi_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b0, 10'(4 + accepts), 46'h0);
      #1;
      if (req_ready_o === 1'b1) begin
        exp_q.push_back(46'(4 + accepts));
        accepts++;
      end
      tick();
    end
    drive(1'b0, 1'b0, 10'h0, 46'h0);
    #1;
    checks++;
    if (accepts !== 3) begin errors++; $display("FAIL bp_accepts: got %0d expected 3", accepts); end
    checks++;
    if (req_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b expected 0", req_ready_o); end
    checks++;
    if (rsp_v_o !== 1'b1) begin errors++; $display("FAIL bp_rsp_v: got %b expected 1", rsp_v_o); end
    e = exp_q.pop_front();
    checks++;
    if (rsp_data_o !== e) begin errors++; $display("FAIL bp_head: got %h expected %h", rsp_data_o, e); end
    rsp_yumi_i = 1'b1;
    tick();
    rsp_yumi_i = 1'b0;
    checks++;
    if (req_ready_o !== 1'b1) begin errors++; $display("FAIL bp_reopen: got %b expected 1", req_ready_o); end
    for (int c = 0; c < 6 && rsp_v_o === 1'b1; c++) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : JUNK;
      checks++;
      if (rsp_data_o !== e) begin errors++; $display("FAIL bp_drain: got %h expected %h", rsp_data_o, e); end
      rsp_yumi_i = 1'b1;
      tick();
      rsp_yumi_i = 1'b0;
    end
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL bp_lost: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_mixed();
    logic [45:0] vals [4];
    logic [45:0] e;
    int got = 0;
    vals[0] = 46'h000_0000_0001;
    vals[1] = 46'h2AA_AAAA_5555;
    vals[2] = 46'h3FF_FFFF_FFFF;
    vals[3] = 46'h123_4567_89AB;
    exp_q.delete();
    for (int s = 0; s < 12; s++) begin
      if (s < 8) drive(1'b1, (s % 2) == 0, 10'h155, (s % 2) == 0 ? vals[s / 2] : 46'h0);
      else drive(1'b0, 1'b0, 10'h0, 46'h0);
      #1;
      if (s < 8) begin
        checks++;
        if (req_ready_o !== 1'b1) begin errors++; $display("FAIL mixed_ready s=%0d: got %b expected 1", s, req_ready_o); end
        if ((s % 2) == 1) exp_q.push_back(vals[s / 2]);
      end
      rsp_yumi_i = rsp_v_o;
      if (rsp_v_o === 1'b1) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : JUNK;
        checks++;
        if (rsp_data_o !== e) begin errors++; $display("FAIL mixed_data s=%0d: got %h expected %h", s, rsp_data_o, e); end
        got++;
      end
      tick();
    end
    rsp_yumi_i = 1'b0;
    checks++;
    if (got !== 4) begin errors++; $display("FAIL mixed_count: got %0d expected 4", got); end
  endtask

  task automatic test_wrap();
    logic [9:0] pat = 10'b1001101001;
    logic [45:0] e;
    int issued = 0;
    int got = 0;
    exp_q.delete();
    for (int c = 0; c < 80 && got < 10; c++) begin
      if (issued < 10) drive(1'b1, 1'b0, 10'(issued), 46'h0);
      else drive(1'b0, 1'b0, 10'h0, 46'h0);
      #1;
      if (req_ready_o === 1'b1 && issued < 10) begin
        exp_q.push_back(46'(issued));
        issued++;
      end
      rsp_yumi_i = pat[c % 10] & rsp_v_o;
      if (rsp_yumi_i === 1'b1) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : JUNK;
        checks++;
        if (rsp_data_o !== e) begin errors++; $display("FAIL wrap_data c=%0d: got %h expected %h", c, rsp_data_o, e); end
        got++;
      end
      tick();
    end
    rsp_yumi_i = 1'b0;
    drive(1'b0, 1'b0, 10'h0, 46'h0);
    checks++;
    if (got !== 10) begin errors++; $display("FAIL wrap_timeout: got %0d responses expected 10", got); end
  endtask

  task automatic test_mid_reset();
    rsp_yumi_i = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      drive(1'b1, 1'b0, 10'(c), 46'h0);
      #1;
      checks++;
      if (req_ready_o !== 1'b1) begin errors++; $display("FAIL mr_ready c=%0d: got %b expected 1", c, req_ready_o); end
      tick();
    end
    drive(1'b1, 1'b0, 10'h003, 46'h0);
    #1;
    checks++;
    if (rsp_v_o !== 1'b1) begin errors++; $display("FAIL mr_pre_rsp_v: got %b expected 1", rsp_v_o); end
    reset_i = 1'b1;
    #1;
    checks++;
    if (rsp_v_o !== 1'b0 || req_ready_o !== 1'b0 || sram_v_o !== 1'b0) begin
      errors++;
      $display("FAIL mr_async: got rsp_v=%b rdy=%b sram_v=%b expected 0 0 0", rsp_v_o, req_ready_o, sram_v_o);
    end
    exp_q.delete();
    tick();
    tick();
    drive(1'b0, 1'b0, 10'h0, 46'h0);
    reset_i = 1'b0;
    #1;
    checks++;
    if (req_ready_o !== 1'b1 || rsp_v_o !== 1'b0) begin
      errors++;
      $display("FAIL mr_release: got rdy=%b rsp_v=%b expected 1 0", req_ready_o, rsp_v_o);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (rsp_v_o !== 1'b0) begin errors++; $display("FAIL mr_stale c=%0d: got %b expected 0", c, rsp_v_o); end
    end
    drive(1'b1, 1'b0, 10'h3FF, 46'h0);
    #1;
    checks++;
    if (req_ready_o !== 1'b1) begin errors++; $display("FAIL mr_new_ready: got %b expected 1", req_ready_o); end
    tick();
    drive(1'b0, 1'b0, 10'h0, 46'h0);
    tick();
    checks++;
    if (rsp_v_o !== 1'b1 || rsp_data_o !== TOP_DATA) begin
      errors++;
      $display("FAIL mr_new_data: got v=%b d=%h expected v=1 d=%h", rsp_v_o, rsp_data_o, TOP_DATA);
    end
    rsp_yumi_i = rsp_v_o;
    tick();
    rsp_yumi_i = 1'b0;
    checks++;
    if (rsp_v_o !== 1'b0) begin errors++; $display("FAIL mr_empty: got %b expected 0", rsp_v_o); end
  endtask

  initial begin
    reset_i    = 1'b1;
    rsp_yumi_i = 1'b0;
    drive(1'b0, 1'b0, 10'h0, 46'h0);
    repeat (2) @(posedge clk_i);
    #1;
    test_reset();
    test_single_read();
    test_streaming();
    test_backpressure();
    test_mixed();
    test_wrap();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
